// File: rtl/trap_ctrl_if.sv
// Trap sequencer bus: pipeline event inputs, CSR-file snapshot, and the
// interrupt-side CSR write port plus fetch redirect.
// master = trap_ctrl side, slave = pipeline / CSR file side.
interface trap_ctrl_if;
    logic        ecall_i;
    logic        ebreak_i;
    logic        mret_i;
    logic [31:0] inst_addr_i;
    logic [31:0] next_pc_i;
    logic        timer_irq_i;
    logic        ext_irq_i;
    logic        global_int_en_i;
    logic [31:0] csr_mtvec_i;
    logic [31:0] csr_mepc_i;
    logic [31:0] csr_mstatus_i;
    logic        ex_csr_we_i;
    logic        csr_we_o;
    logic [31:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        hold_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;

    modport master (
        input  ecall_i, ebreak_i, mret_i, inst_addr_i, next_pc_i,
               timer_irq_i, ext_irq_i, global_int_en_i,
               csr_mtvec_i, csr_mepc_i, csr_mstatus_i, ex_csr_we_i,
        output csr_we_o, csr_waddr_o, csr_wdata_o, hold_o,
               jump_flag_o, jump_addr_o
    );

    modport slave (
        output ecall_i, ebreak_i, mret_i, inst_addr_i, next_pc_i,
               timer_irq_i, ext_irq_i, global_int_en_i,
               csr_mtvec_i, csr_mepc_i, csr_mstatus_i, ex_csr_we_i,
        input  csr_we_o, csr_waddr_o, csr_wdata_o, hold_o,
               jump_flag_o, jump_addr_o
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: writes mepc/mcause/(mtval)/mstatus through the
// shared CSR port, yielding to EX writes, then redirects fetch.
// Optional: define TRAP_MTVAL_EN to add the mtval write state.
module trap_ctrl #(
    parameter logic [31:0] MCAUSE_TIMER  = 32'h8000_0007,
    parameter logic [31:0] MCAUSE_EXT    = 32'h8000_000B,
    parameter logic [31:0] MCAUSE_ECALL  = 32'd11,
    parameter logic [31:0] MCAUSE_EBREAK = 32'd3
) (
    input logic         clk,
    input logic         rst,
    trap_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_MEPC,
        S_WR_MCAUSE,
`ifdef TRAP_MTVAL_EN
        S_WR_MTVAL,
`endif
        S_WR_MSTATUS,
        S_MRET_MSTATUS,
        S_JUMP
    } state_t;

    state_t      state_q, state_d;
    logic        evt_trap, evt_mret;
    logic [31:0] evt_cause, evt_epc;
    logic [31:0] cause_q, epc_q;
    logic        mret_q;
`ifdef TRAP_MTVAL_EN
    logic [31:0] evt_mtval, mtval_q;
`endif
    logic        wr_req, we;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic [31:0] ms_trap, ms_mret;
    logic        port_free;
    logic        irq_ext, irq_tmr;

    assign port_free = !bus.ex_csr_we_i;
    assign irq_ext   = bus.ext_irq_i && bus.global_int_en_i;
    assign irq_tmr   = bus.timer_irq_i && bus.global_int_en_i;

    // Pick the highest-priority event; sync exceptions beat interrupts.
    always_comb begin
        evt_trap  = 1'b0;
        evt_mret  = 1'b0;
        evt_cause = 32'd0;
        evt_epc   = 32'd0;
`ifdef TRAP_MTVAL_EN
        evt_mtval = 32'd0;
`endif
        if (state_q == S_IDLE) begin
            if (bus.ecall_i) begin
                evt_trap  = 1'b1;
                evt_cause = MCAUSE_ECALL;
                evt_epc   = bus.inst_addr_i;
            end else if (bus.ebreak_i) begin
                evt_trap  = 1'b1;
                evt_cause = MCAUSE_EBREAK;
                evt_epc   = bus.inst_addr_i;
`ifdef TRAP_MTVAL_EN
                evt_mtval = bus.inst_addr_i;
`endif
            end else if (bus.mret_i) begin
                evt_mret  = 1'b1;
            end else if (irq_ext) begin
                evt_trap  = 1'b1;
                evt_cause = MCAUSE_EXT;
                evt_epc   = bus.next_pc_i;
            end else if (irq_tmr) begin
                evt_trap  = 1'b1;
                evt_cause = MCAUSE_TIMER;
                evt_epc   = bus.next_pc_i;
            end
        end
    end

    // Capture cause/epc (and mtval) when an event is accepted in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause_q <= 32'd0;
            epc_q   <= 32'd0;
            mret_q  <= 1'b0;
`ifdef TRAP_MTVAL_EN
            mtval_q <= 32'd0;
`endif
        end else if (evt_trap) begin
            cause_q <= evt_cause;
            epc_q   <= evt_epc;
            mret_q  <= 1'b0;
`ifdef TRAP_MTVAL_EN
            mtval_q <= evt_mtval;
`endif
        end else if (evt_mret) begin
            mret_q  <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state: write states only advance when the port was ours.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (evt_trap)      state_d = S_WR_MEPC;
                else if (evt_mret) state_d = S_MRET_MSTATUS;
            end
            S_WR_MEPC:      if (port_free) state_d = S_WR_MCAUSE;
`ifdef TRAP_MTVAL_EN
            S_WR_MCAUSE:    if (port_free) state_d = S_WR_MTVAL;
            S_WR_MTVAL:     if (port_free) state_d = S_WR_MSTATUS;
`else
            S_WR_MCAUSE:    if (port_free) state_d = S_WR_MSTATUS;
`endif
            S_WR_MSTATUS:   if (port_free) state_d = S_JUMP;
            S_MRET_MSTATUS: if (port_free) state_d = S_JUMP;
            S_JUMP:         state_d = S_IDLE;
            default:        state_d = S_IDLE;
        endcase
    end

    // mstatus images for trap entry and mret.
    always_comb begin
        ms_trap        = bus.csr_mstatus_i;
        ms_trap[7]     = bus.csr_mstatus_i[3];
        ms_trap[3]     = 1'b0;
        ms_trap[12:11] = 2'b11;
        ms_mret        = bus.csr_mstatus_i;
        ms_mret[3]     = bus.csr_mstatus_i[7];
        ms_mret[7]     = 1'b1;
    end

    // Outputs: one CSR write per write state, redirect in JUMP, data zeroed off-strobe.
    always_comb begin
        wr_req          = 1'b0;
        wr_addr         = 12'h000;
        wr_data         = 32'd0;
        bus.jump_flag_o = 1'b0;
        bus.jump_addr_o = 32'd0;
        bus.hold_o      = (state_q != S_IDLE) || evt_trap || evt_mret;
        case (state_q)
            S_WR_MEPC:      begin wr_req = 1'b1; wr_addr = 12'h341; wr_data = epc_q;   end
            S_WR_MCAUSE:    begin wr_req = 1'b1; wr_addr = 12'h342; wr_data = cause_q; end
`ifdef TRAP_MTVAL_EN
            S_WR_MTVAL:     begin wr_req = 1'b1; wr_addr = 12'h343; wr_data = mtval_q; end
`endif
            S_WR_MSTATUS:   begin wr_req = 1'b1; wr_addr = 12'h300; wr_data = ms_trap; end
            S_MRET_MSTATUS: begin wr_req = 1'b1; wr_addr = 12'h300; wr_data = ms_mret; end
            S_JUMP: begin
                bus.jump_flag_o = 1'b1;
                bus.jump_addr_o = mret_q ? bus.csr_mepc_i
                                         : (bus.csr_mtvec_i & 32'hFFFF_FFFC);
            end
            default: ;
        endcase
        we              = wr_req && port_free;
        bus.csr_we_o    = we;
        bus.csr_waddr_o = we ? {20'd0, wr_addr} : 32'd0;
        bus.csr_wdata_o = we ? wr_data : 32'd0;
    end
endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;
`ifdef TRAP_MTVAL_EN
    localparam int M = 1;
`else
    localparam int M = 0;
`endif

    typedef struct {
        int          cyc;
        bit          jmp;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic clk, rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   n;
    exp_t sb[$];

    trap_ctrl_if bus ();
    trap_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input int c, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.cyc = c; e.jmp = 1'b0; e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    task automatic push_jmp(input int c, input logic [31:0] a);
        exp_t e;
        e.cyc = c; e.jmp = 1'b1; e.addr = a; e.data = 32'd0;
        sb.push_back(e);
    endtask

    // Full trap sequence expected from event cycle c; s = EX stall cycles in WR_MCAUSE.
    task automatic push_trap(input int c, input logic [31:0] epc, input logic [31:0] cause,
                             input logic [31:0] mtval, input logic [31:0] mst,
                             input logic [31:0] jaddr, input int s);
        push_wr(c + 1, 32'h341, epc);
        push_wr(c + 2 + s, 32'h342, cause);
        if (M == 1) push_wr(c + 3 + s, 32'h343, mtval);
        push_wr(c + 3 + s + M, 32'h300, mst);
        push_jmp(c + 4 + s + M, jaddr);
    endtask

    // Step through len busy cycles, hold must stay high; then expect IDLE.
    task automatic run_seq(input int len, input bit clr_irq, input bit end_idle);
        for (int i = 1; i <= len; i++) begin
            step();
            bus.ecall_i = 1'b0; bus.ebreak_i = 1'b0; bus.mret_i = 1'b0;
            if (clr_irq) begin bus.ext_irq_i = 1'b0; bus.timer_irq_i = 1'b0; end
            #1;
            chk("hold_busy", {31'd0, bus.hold_o}, 32'd1);
        end
        if (end_idle) begin
            step();
            #1;
            chk("hold_idle", {31'd0, bus.hold_o}, 32'd0);
        end
    endtask

    // Scoreboard monitor: pop on every strobe, check zeroing off-strobe.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (bus.csr_we_o || bus.jump_flag_o) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_out @cyc %0d: got we=%0b jmp=%0b waddr=%h wdata=%h jaddr=%h expected none",
                             cyc, bus.csr_we_o, bus.jump_flag_o, bus.csr_waddr_o, bus.csr_wdata_o, bus.jump_addr_o);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("kind_jmp", {31'd0, bus.jump_flag_o}, {31'd0, e.jmp});
                    chk("cycle", cyc, e.cyc);
                    if (e.jmp) begin
                        chk("jump_addr", bus.jump_addr_o, e.addr);
                    end else begin
                        chk("csr_waddr", bus.csr_waddr_o, e.addr);
                        chk("csr_wdata", bus.csr_wdata_o, e.data);
                    end
                end
            end
            if (!bus.csr_we_o)    chk("wdata_zero", bus.csr_wdata_o, 32'd0);
            if (!bus.jump_flag_o) chk("jaddr_zero", bus.jump_addr_o, 32'd0);
        end
    end

    initial begin
        rst = 1'b1;
        bus.ecall_i = 1'b0; bus.ebreak_i = 1'b0; bus.mret_i = 1'b0;
        bus.inst_addr_i = 32'd0; bus.next_pc_i = 32'd0;
        bus.timer_irq_i = 1'b0; bus.ext_irq_i = 1'b0; bus.global_int_en_i = 1'b0;
        bus.csr_mtvec_i = 32'd0; bus.csr_mepc_i = 32'd0; bus.csr_mstatus_i = 32'd0;
        bus.ex_csr_we_i = 1'b0;
        repeat (3) step();
        chk("rst_we",    {31'd0, bus.csr_we_o}, 32'd0);
        chk("rst_waddr", bus.csr_waddr_o, 32'd0);
        chk("rst_wdata", bus.csr_wdata_o, 32'd0);
        chk("rst_hold",  {31'd0, bus.hold_o}, 32'd0);
        chk("rst_jflag", {31'd0, bus.jump_flag_o}, 32'd0);
        chk("rst_jaddr", bus.jump_addr_o, 32'd0);
        rst = 1'b0;
        step();

        // ecall from 0x100, MIE=1
        bus.csr_mstatus_i = 32'h8; bus.csr_mtvec_i = 32'h203; bus.inst_addr_i = 32'h100;
        bus.ecall_i = 1'b1; n = cyc; #1;
        chk("hold_evt_ecall", {31'd0, bus.hold_o}, 32'd1);
        push_trap(n, 32'h100, 32'd11, 32'd0, 32'h1880, 32'h200, 0);
        run_seq(4 + M, 1'b1, 1'b1);

        // timer interrupt enabled
        bus.next_pc_i = 32'h204; bus.timer_irq_i = 1'b1; bus.global_int_en_i = 1'b1;
        n = cyc; #1;
        chk("hold_evt_timer", {31'd0, bus.hold_o}, 32'd1);
        push_trap(n, 32'h204, 32'h8000_0007, 32'd0, 32'h1880, 32'h200, 0);
        run_seq(4 + M, 1'b1, 1'b1);

        // timer interrupt masked: nothing happens
        bus.timer_irq_i = 1'b1; bus.global_int_en_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("hold_masked", {31'd0, bus.hold_o}, 32'd0);
            step();
        end
        bus.timer_irq_i = 1'b0;

        // mret
        bus.csr_mstatus_i = 32'h1880; bus.csr_mepc_i = 32'h104;
        bus.mret_i = 1'b1; n = cyc; #1;
        chk("hold_evt_mret", {31'd0, bus.hold_o}, 32'd1);
        push_wr(n + 1, 32'h300, 32'h1888);
        push_jmp(n + 2, 32'h104);
        run_seq(2, 1'b1, 1'b1);

        // EX owns the port for 3 cycles during WR_MCAUSE
        bus.csr_mstatus_i = 32'h8; bus.inst_addr_i = 32'h300;
        bus.ecall_i = 1'b1; n = cyc;
        push_trap(n, 32'h300, 32'd11, 32'd0, 32'h1880, 32'h200, 3);
        for (int i = 1; i <= 7 + M; i++) begin
            step();
            bus.ecall_i = 1'b0;
            bus.ex_csr_we_i = (i >= 2 && i <= 4);
            #1;
            chk("hold_stall", {31'd0, bus.hold_o}, 32'd1);
            if (i >= 2 && i <= 4) chk("we_yield", {31'd0, bus.csr_we_o}, 32'd0);
        end
        bus.ex_csr_we_i = 1'b0;
        step(); #1;
        chk("hold_idle_stall", {31'd0, bus.hold_o}, 32'd0);

        // ecall and external interrupt together: ecall first, then the irq
        bus.inst_addr_i = 32'h400; bus.next_pc_i = 32'h404;
        bus.global_int_en_i = 1'b1; bus.ext_irq_i = 1'b1; bus.ecall_i = 1'b1;
        n = cyc;
        push_trap(n, 32'h400, 32'd11, 32'd0, 32'h1880, 32'h200, 0);
        run_seq(4 + M, 1'b0, 1'b0);
        step();
        n = cyc; #1;
        chk("hold_evt_ext", {31'd0, bus.hold_o}, 32'd1);
        push_trap(n, 32'h404, 32'h8000_000B, 32'd0, 32'h1880, 32'h200, 0);
        run_seq(4 + M, 1'b1, 1'b1);
        bus.global_int_en_i = 1'b0;

        // reset during WR_MCAUSE, then a clean ebreak
        bus.inst_addr_i = 32'h500; bus.ebreak_i = 1'b1; n = cyc;
        push_wr(n + 1, 32'h341, 32'h500);
        step(); bus.ebreak_i = 1'b0;
        step();
        rst = 1'b1; #1;
        chk("midrst_we",    {31'd0, bus.csr_we_o}, 32'd0);
        chk("midrst_waddr", bus.csr_waddr_o, 32'd0);
        chk("midrst_wdata", bus.csr_wdata_o, 32'd0);
        chk("midrst_hold",  {31'd0, bus.hold_o}, 32'd0);
        chk("midrst_jflag", {31'd0, bus.jump_flag_o}, 32'd0);
        step();
        rst = 1'b0;
        step();
        bus.inst_addr_i = 32'h600; bus.ebreak_i = 1'b1; n = cyc; #1;
        chk("hold_evt_ebreak", {31'd0, bus.hold_o}, 32'd1);
        push_trap(n, 32'h600, 32'd3, 32'h600, 32'h1880, 32'h200, 0);
        run_seq(4 + M, 1'b1, 1'b1);

        repeat (3) step();
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
